if_id_ex_mem: RTL and testbench

Pipeline register bank for the 5-stage MIPS core. It holds the IF/ID, ID/EX and EX/MEM stage latches in one block. Each stage has its own advance (go) and flush (clear) controls, so the hazard unit can stall or bubble any stage independently. Forward paths between stages are internal: ID/EX loads from the IF/ID outputs, and EX/MEM loads its instruction from the ID/EX outputs.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/pipe_reg.sv | 23 ++
 rtl/if_id_ex_mem.sv | 120 ++++++++++++
 tb/tb_if_id_ex_mem.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, NOP encoding and ctrl_msg bit positions for the MIPS pipeline
package mips_pkg;

  localparam int PC_W    = 12;
  localparam int XLEN    = 32;
  localparam int CTRL_W  = 15;
  localparam int REDIR_W = 4;

  // sll $0,$0,0 encodes as all zeros, so a cleared stage is a NOP
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  localparam int CTRL_RAM_LOAD  = 14;
  localparam int CTRL_RW_T_HI   = 13;
  localparam int CTRL_RW_T_LO   = 12;
  localparam int CTRL_W_HI      = 11;
  localparam int CTRL_W_LO      = 10;
  localparam int CTRL_WE        = 9;
  localparam int CTRL_SYSCALL   = 8;
  localparam int CTRL_RAM_STO   = 3;
  localparam int CTRL_HALF_WORD = 2;

  localparam int IF_ID_W  = PC_W + XLEN;
  localparam int ID_EX_W  = PC_W + 3 * XLEN + REDIR_W;
  localparam int EX_MEM_W = 4 * XLEN + CTRL_W;

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - one pipeline latch field group with clear > go > hold priority
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (go) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_ex_mem.sv
// rtl/if_id_ex_mem.sv - IF/ID, ID/EX and EX/MEM stage latches; PIPE_VALID_EN adds per-stage valid bits
module if_id_ex_mem
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
`ifdef PIPE_VALID_EN
  output logic               id_valid,
  output logic               ex_valid,
  output logic               mem_valid,
`endif
  input  logic [PC_W-1:0]    if_pc4,
  input  logic [XLEN-1:0]    if_instr,
  input  logic               if_go_a,
  input  logic               if_go_b,
  input  logic               if_clear,
  output logic [PC_W-1:0]    id_pc4,
  output logic [XLEN-1:0]    id_instr,
  input  logic [XLEN-1:0]    id_a,
  input  logic [XLEN-1:0]    id_b,
  input  logic [REDIR_W-1:0] id_redir,
  input  logic               ex_go,
  input  logic               ex_clear_a,
  input  logic               ex_clear_b,
  output logic [PC_W-1:0]    ex_pc4,
  output logic [XLEN-1:0]    ex_instr,
  output logic [XLEN-1:0]    ex_a,
  output logic [XLEN-1:0]    ex_b,
  output logic [REDIR_W-1:0] ex_redir,
  input  logic [CTRL_W-1:0]  ex_ctrl,
  input  logic [XLEN-1:0]    ex_alu,
  input  logic [XLEN-1:0]    ex_a_fwd,
  input  logic [XLEN-1:0]    ex_b_fwd,
  input  logic               mem_go,
  input  logic               mem_clear,
  output logic [XLEN-1:0]    mem_instr,
  output logic [CTRL_W-1:0]  mem_ctrl,
  output logic [XLEN-1:0]    mem_alu,
  output logic [XLEN-1:0]    mem_a,
  output logic [XLEN-1:0]    mem_b
);

  logic if_go_eff;
  logic ex_clear_eff;

  logic [IF_ID_W-1:0]  if_id_d,  if_id_q;
  logic [ID_EX_W-1:0]  id_ex_d,  id_ex_q;
  logic [EX_MEM_W-1:0] ex_mem_d, ex_mem_q;

  assign if_go_eff    = if_go_a & if_go_b;
  assign ex_clear_eff = ex_clear_a | ex_clear_b;

  assign if_id_d = {if_pc4, if_instr};
  assign {id_pc4, id_instr} = if_id_q;

  // ID/EX pc4/instr forward from the IF/ID latch, not from the IF ports
  assign id_ex_d = {id_pc4, id_instr, id_a, id_b, id_redir};
  assign {ex_pc4, ex_instr, ex_a, ex_b, ex_redir} = id_ex_q;

  assign ex_mem_d = {ex_instr, ex_ctrl, ex_alu, ex_a_fwd, ex_b_fwd};
  assign {mem_instr, mem_ctrl, mem_alu, mem_a, mem_b} = ex_mem_q;

  pipe_reg #(.W(IF_ID_W)) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .go    (if_go_eff),
    .clear (if_clear),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  pipe_reg #(.W(ID_EX_W)) u_id_ex (
    .clk   (clk),
    .rst   (rst),
    .go    (ex_go),
    .clear (ex_clear_eff),
    .d     (id_ex_d),
    .q     (id_ex_q)
  );

  pipe_reg #(.W(EX_MEM_W)) u_ex_mem (
    .clk   (clk),
    .rst   (rst),
    .go    (mem_go),
    .clear (mem_clear),
    .d     (ex_mem_d),
    .q     (ex_mem_q)
  );

`ifdef PIPE_VALID_EN
  // Valid bits ride the same clear/go/hold rule as the data they qualify
  pipe_reg #(.W(1)) u_id_valid (
    .clk   (clk),
    .rst   (rst),
    .go    (if_go_eff),
    .clear (if_clear),
    .d     (1'b1),
    .q     (id_valid)
  );

  pipe_reg #(.W(1)) u_ex_valid (
    .clk   (clk),
    .rst   (rst),
    .go    (ex_go),
    .clear (ex_clear_eff),
    .d     (id_valid),
    .q     (ex_valid)
  );

  pipe_reg #(.W(1)) u_mem_valid (
    .clk   (clk),
    .rst   (rst),
    .go    (mem_go),
    .clear (mem_clear),
    .d     (ex_valid),
    .q     (mem_valid)
  );
`endif

endmodule

// File: tb/tb_if_id_ex_mem.sv
// tb/tb_if_id_ex_mem.sv - directed table-driven bench for the if_id_ex_mem pipeline register bank
module tb_if_id_ex_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] if_pc4;
  logic [31:0] if_instr;
  logic        if_go_a, if_go_b, if_clear;
  logic [11:0] id_pc4;
  logic [31:0] id_instr;
  logic [31:0] id_a, id_b;
  logic [3:0]  id_redir;
  logic        ex_go, ex_clear_a, ex_clear_b;
  logic [11:0] ex_pc4;
  logic [31:0] ex_instr, ex_a, ex_b;
  logic [3:0]  ex_redir;
  logic [14:0] ex_ctrl;
  logic [31:0] ex_alu, ex_a_fwd, ex_b_fwd;
  logic        mem_go, mem_clear;
  logic [31:0] mem_instr;
  logic [14:0] mem_ctrl;
  logic [31:0] mem_alu, mem_a, mem_b;
`ifdef PIPE_VALID_EN
  logic        id_valid, ex_valid, mem_valid;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_id_ex_mem dut (
    .clk        (clk),
    .rst        (rst),
`ifdef PIPE_VALID_EN
    .id_valid   (id_valid),
    .ex_valid   (ex_valid),
    .mem_valid  (mem_valid),
`endif
    .if_pc4     (if_pc4),
    .if_instr   (if_instr),
    .if_go_a    (if_go_a),
    .if_go_b    (if_go_b),
    .if_clear   (if_clear),
    .id_pc4     (id_pc4),
    .id_instr   (id_instr),
    .id_a       (id_a),
    .id_b       (id_b),
    .id_redir   (id_redir),
    .ex_go      (ex_go),
    .ex_clear_a (ex_clear_a),
    .ex_clear_b (ex_clear_b),
    .ex_pc4     (ex_pc4),
    .ex_instr   (ex_instr),
    .ex_a       (ex_a),
    .ex_b       (ex_b),
    .ex_redir   (ex_redir),
    .ex_ctrl    (ex_ctrl),
    .ex_alu     (ex_alu),
    .ex_a_fwd   (ex_a_fwd),
    .ex_b_fwd   (ex_b_fwd),
    .mem_go     (mem_go),
    .mem_clear  (mem_clear),
    .mem_instr  (mem_instr),
    .mem_ctrl   (mem_ctrl),
    .mem_alu    (mem_alu),
    .mem_a      (mem_a),
    .mem_b      (mem_b)
  );

  typedef struct {
    logic        go_a, go_b, if_clr, ex_g, ex_clr_a, ex_clr_b, mem_g, mem_clr;
    logic [31:0] instr, a, alu;
    logic [14:0] ctrl;
    logic [31:0] e_id, e_ex, e_ex_a, e_mem;
    logic [14:0] e_ctrl;
    logic [31:0] e_alu;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] ins(int k);
    case (k)
      1:       return 32'h2008_0005;
      2:       return 32'h0000_000C;
      3:       return 32'h8C09_0004;
      4:       return 32'hAC0A_0008;
      default: return 32'h2200_0000 + 32'(k);
    endcase
  endfunction

  function automatic logic [31:0] av(int k);
    return 32'hA000_0000 + 32'(k);
  endfunction

  function automatic logic [31:0] lv(int k);
    return 32'hB000_0000 + 32'(k);
  endfunction

  function automatic logic [14:0] cv(int k);
    return 15'h1000 + 15'(k);
  endfunction

  function automatic logic [298:0] all_out();
    return {id_pc4, id_instr, ex_pc4, ex_instr, ex_a, ex_b, ex_redir,
            mem_instr, mem_ctrl, mem_alu, mem_a, mem_b};
  endfunction

  task automatic check(input string nm, input logic [298:0] act, input logic [298:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] c, input int k, input logic [14:0] ctl,
                     input logic [31:0] e_id, e_ex, e_ex_a, e_mem,
                     input logic [14:0] e_ctrl, input logic [31:0] e_alu);
    vec_t v;
    {v.go_a, v.go_b, v.if_clr, v.ex_g, v.ex_clr_a, v.ex_clr_b, v.mem_g, v.mem_clr} = c;
    v.instr = ins(k);
    v.a = av(k);
    v.alu = lv(k);
    v.ctrl = ctl;
    v.e_id = e_id;
    v.e_ex = e_ex;
    v.e_ex_a = e_ex_a;
    v.e_mem = e_mem;
    v.e_ctrl = e_ctrl;
    v.e_alu = e_alu;
    vecs.push_back(v);
  endtask

  task automatic set_ctl(input logic [7:0] c);
    {if_go_a, if_go_b, if_clear, ex_go, ex_clear_a, ex_clear_b, mem_go, mem_clear} = c;
  endtask

  // control bit order: go_a go_b if_clr ex_go ex_clr_a ex_clr_b mem_go mem_clr
  localparam logic [7:0] ALL_GO = 8'b1101_0010;

  initial begin
    // flow
    add(ALL_GO, 1, cv(1), ins(1), 0, av(1), 0, cv(1), lv(1));
    add(ALL_GO, 2, cv(2), ins(2), ins(1), av(2), 0, cv(2), lv(2));
    add(ALL_GO, 3, cv(3), ins(3), ins(2), av(3), ins(1), cv(3), lv(3));
    add(ALL_GO, 4, cv(4), ins(4), ins(3), av(4), ins(2), cv(4), lv(4));
    // stall IF/ID (go_b=0) and ID/EX, EX/MEM keeps loading the held EX values
    add(8'b1000_0010, 5, cv(5), ins(4), ins(3), av(4), ins(3), cv(5), lv(5));
    add(8'b1000_0010, 6, cv(6), ins(4), ins(3), av(4), ins(3), cv(6), lv(6));
    // bubble via ex_clear_a while IF/ID holds, then release
    add(8'b0001_1010, 7, cv(7), ins(4), 0, 0, ins(3), cv(7), lv(7));
    add(ALL_GO, 8, cv(8), ins(8), ins(4), av(8), 0, cv(8), lv(8));
    add(8'b1101_0110, 9, cv(9), ins(9), 0, 0, ins(4), cv(9), lv(9));
    // clear beats go on EX/MEM
    add(8'b1101_0011, 10, 15'h7FFF, ins(10), ins(9), av(10), 0, 0, 0);
    add(8'b1111_0010, 11, cv(11), 0, ins(10), av(11), ins(9), cv(11), lv(11));
    add(8'b1101_0000, 12, cv(12), ins(12), 0, av(12), ins(9), cv(11), lv(11));
    add(ALL_GO, 13, cv(13), ins(13), ins(12), av(13), 0, cv(13), lv(13));
    add(8'b0101_0010, 14, cv(14), ins(13), ins(13), av(14), ins(12), cv(14), lv(14));

    // reset with random inputs, then first load
    rst = 1'b0;
    set_ctl(ALL_GO);
    if_pc4 = 12'($urandom);
    if_instr = $urandom;
    id_a = $urandom;
    id_b = $urandom;
    id_redir = 4'($urandom);
    ex_ctrl = 15'($urandom);
    ex_alu = $urandom;
    ex_a_fwd = $urandom;
    ex_b_fwd = $urandom;
    repeat (3) @(posedge clk);
    #1 check("reset_all_zero", all_out(), '0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("post_release_before_edge", all_out(), '0);
    @(posedge clk);
    #1 check("first_load_id_instr", {267'd0, id_instr}, {267'd0, if_instr});
    check("first_load_id_pc4", {287'd0, id_pc4}, {287'd0, if_pc4});

    // fresh zero state; controls idle so release edge does nothing
    @(negedge clk);
    set_ctl(8'h00);
    rst = 1'b0;
    #1 rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      set_ctl({vecs[i].go_a, vecs[i].go_b, vecs[i].if_clr, vecs[i].ex_g,
               vecs[i].ex_clr_a, vecs[i].ex_clr_b, vecs[i].mem_g, vecs[i].mem_clr});
      if_instr = vecs[i].instr;
      if_pc4 = 12'(i * 4);
      id_a = vecs[i].a;
      id_b = ~vecs[i].a;
      id_redir = 4'(i);
      ex_ctrl = vecs[i].ctrl;
      ex_alu = vecs[i].alu;
      ex_a_fwd = vecs[i].a;
      ex_b_fwd = vecs[i].alu;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_id_instr", i), {267'd0, id_instr}, {267'd0, vecs[i].e_id});
      check($sformatf("v%0d_ex_instr", i), {267'd0, ex_instr}, {267'd0, vecs[i].e_ex});
      check($sformatf("v%0d_ex_a", i), {267'd0, ex_a}, {267'd0, vecs[i].e_ex_a});
      check($sformatf("v%0d_mem_instr", i), {267'd0, mem_instr}, {267'd0, vecs[i].e_mem});
      check($sformatf("v%0d_mem_ctrl", i), {284'd0, mem_ctrl}, {284'd0, vecs[i].e_ctrl});
      check($sformatf("v%0d_mem_alu", i), {267'd0, mem_alu}, {267'd0, vecs[i].e_alu});
    end

    // remaining fields pass through unchanged
    @(negedge clk);
    set_ctl(ALL_GO);
    if_pc4 = 12'hABC;
    if_instr = 32'h0123_4567;
    id_a = 32'hA5A5_A5A5;
    id_b = 32'h5A5A_5A5A;
    id_redir = 4'h9;
    ex_ctrl = 15'h2AAA;
    ex_alu = 32'hDEAD_BEEF;
    ex_a_fwd = 32'hCAFE_0001;
    ex_b_fwd = 32'hCAFE_0002;
    @(posedge clk);
    #1;
    check("pt_id_pc4", {287'd0, id_pc4}, {287'd0, 12'hABC});
    check("pt_ex_b", {267'd0, ex_b}, {267'd0, 32'h5A5A_5A5A});
    check("pt_ex_redir", {295'd0, ex_redir}, {295'd0, 4'h9});
    check("pt_mem_a", {267'd0, mem_a}, {267'd0, 32'hCAFE_0001});
    check("pt_mem_b", {267'd0, mem_b}, {267'd0, 32'hCAFE_0002});
    @(posedge clk);
    #1 check("pt_ex_pc4", {287'd0, ex_pc4}, {287'd0, 12'hABC});
    @(posedge clk);
    #1 check("pt_mem_instr_3_edges", {267'd0, mem_instr}, {267'd0, 32'h0123_4567});

    // asynchronous reset between edges
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("async_reset_mid_cycle", all_out(), '0);
    #2 rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
